// File: rtl/scaler_h_mc.sv
// Horizontal multi-channel downscaler: bypass, nearest or linear resampling of one line
// at a time with a fixed three-cycle latency from input pixel to output pixel.
module scaler_h_mc #(
    parameter int DATA_WIDTH    = 8,
    parameter int CH_COUNT      = 3,
    parameter int FRAC_W        = 12,
    parameter int INT_W         = 4,
    parameter int LINE_SIZE_MAX = 4096
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [INT_W+FRAC_W-1:0]               scale_step,
    input  logic [1:0]                            mode,
    input  logic [DATA_WIDTH*CH_COUNT-1:0]        di_i,
    input  logic                                  de_i,
    input  logic                                  hs_i,
    input  logic                                  vs_i,
    output logic [DATA_WIDTH*CH_COUNT-1:0]        do_o,
    output logic                                  de_o,
    output logic                                  hs_o,
    output logic                                  vs_o,
    output logic [$clog2(LINE_SIZE_MAX):0]        pix_cnt_o
);

    localparam int PW   = DATA_WIDTH * CH_COUNT;
    localparam int SW   = INT_W + FRAC_W;
    localparam int NW   = $clog2(LINE_SIZE_MAX);
    localparam int POSW = SW + NW;
    localparam int PIW  = POSW - FRAC_W;
    localparam int CW   = NW + 1;
    localparam int AW   = DATA_WIDTH + FRAC_W + 1;
    localparam int FW1  = FRAC_W + 1;

    localparam logic [SW-1:0] STEP_ONE = SW'(1) << FRAC_W;
    localparam logic [NW-1:0] N_MAX    = NW'(LINE_SIZE_MAX - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    // Rounded two-tap blend of one channel; the accumulator is wide enough that it cannot overflow.
    function automatic logic [DATA_WIDTH-1:0] lerp_ch(
        input logic [DATA_WIDTH-1:0] p0,
        input logic [DATA_WIDTH-1:0] p1,
        input logic [FRAC_W-1:0]     f
    );
        logic [FW1-1:0] w0;
        logic [AW-1:0]  acc;
        w0  = (FW1'(1) << FRAC_W) - {1'b0, f};
        acc = AW'(p0) * AW'(w0) + AW'(p1) * AW'(f) + (AW'(1) << (FRAC_W - 1));
        return acc[FRAC_W +: DATA_WIDTH];
    endfunction

    // Per-channel output pixel for the latched mode; all channels share the same phase.
    function automatic logic [PW-1:0] pixel_out(
        input logic [1:0]        m,
        input logic [PW-1:0]     p0,
        input logic [PW-1:0]     p1,
        input logic [FRAC_W-1:0] f
    );
        logic [PW-1:0] r;
        r = '0;
        for (int c = 0; c < CH_COUNT; c++) begin
            case (m)
                2'd0:    r[c*DATA_WIDTH +: DATA_WIDTH] = p0[c*DATA_WIDTH +: DATA_WIDTH];
                2'd1:    r[c*DATA_WIDTH +: DATA_WIDTH] = f[FRAC_W-1] ? p1[c*DATA_WIDTH +: DATA_WIDTH]
                                                                     : p0[c*DATA_WIDTH +: DATA_WIDTH];
                default: r[c*DATA_WIDTH +: DATA_WIDTH] = lerp_ch(p0[c*DATA_WIDTH +: DATA_WIDTH],
                                                                 p1[c*DATA_WIDTH +: DATA_WIDTH], f);
            endcase
        end
        return r;
    endfunction

    logic [2:0]        hs_dly_q, hs_dly_d, vs_dly_q, vs_dly_d;
    logic              hs_prev_q, hs_prev_d;
    logic              line_ok_q, line_ok_d;
    logic              armed_q, armed_d;
    logic [SW-1:0]     step_q, step_d;
    logic [1:0]        mode_q, mode_d;
    logic [NW-1:0]     n_q, n_d;
    logic [POSW-1:0]   pos_q, pos_d;
    logic [PW-1:0]     prev_q, prev_d;
    logic [CW-1:0]     cnt_q, cnt_d, pix_cnt_q, pix_cnt_d;
    logic              s1_vld_q, s1_vld_d;
    logic [1:0]        s1_mode_q, s1_mode_d;
    logic [PW-1:0]     s1_p0_q, s1_p0_d, s1_p1_q, s1_p1_d;
    logic [FRAC_W-1:0] s1_f_q, s1_f_d;
    logic              s2_vld_q, s2_vld_d;
    logic [PW-1:0]     s2_pix_q, s2_pix_d;
    logic              de_q, de_d;
    logic [PW-1:0]     do_q, do_d;

    logic              qual_s;
    logic [SW-1:0]     step_in_s, step_eff_s;
    logic [1:0]        mode_eff_s;
    logic [PIW-1:0]    pos_int_s, n_prev_s;

    // Line control, sample position tracking and first pipeline stage.
    always_comb begin
        hs_dly_d   = {hs_dly_q[1:0], hs_i};
        vs_dly_d   = {vs_dly_q[1:0], vs_i};
        hs_prev_d  = hs_i;
        line_ok_d  = line_ok_q;
        armed_d    = armed_q;
        step_d     = step_q;
        mode_d     = mode_q;
        n_d        = n_q;
        pos_d      = pos_q;
        prev_d     = prev_q;
        cnt_d      = cnt_q;
        pix_cnt_d  = pix_cnt_q;
        s1_vld_d   = 1'b0;
        s1_mode_d  = s1_mode_q;
        s1_p0_d    = s1_p0_q;
        s1_p1_d    = s1_p1_q;
        s1_f_d     = s1_f_q;

        qual_s     = de_i & ~hs_i & line_ok_q;
        step_in_s  = (scale_step < STEP_ONE) ? STEP_ONE : scale_step;
        step_eff_s = armed_q ? step_in_s : step_q;
        mode_eff_s = armed_q ? mode : mode_q;
        pos_int_s  = pos_q[POSW-1:FRAC_W];
        n_prev_s   = PIW'(n_q - NW'(1));

        if (hs_i) begin
            n_d       = '0;
            pos_d     = '0;
            prev_d    = '0;
            armed_d   = 1'b1;
            line_ok_d = 1'b1;
        end else if (qual_s) begin
            armed_d   = 1'b0;
            step_d    = step_eff_s;
            mode_d    = mode_eff_s;
            prev_d    = di_i;
            n_d       = (n_q == N_MAX) ? n_q : n_q + NW'(1);
            s1_mode_d = mode_eff_s;
            if (mode_eff_s == 2'd0) begin
                s1_vld_d = 1'b1;
                s1_p0_d  = di_i;
            end else if ((n_q != '0) && (pos_int_s == n_prev_s)) begin
                s1_vld_d = 1'b1;
                s1_p0_d  = prev_q;
                s1_p1_d  = di_i;
                s1_f_d   = pos_q[FRAC_W-1:0];
                pos_d    = pos_q + POSW'(step_eff_s);
            end else begin
                s1_vld_d = 1'b0;
            end
        end else begin
            s1_vld_d = 1'b0;
        end

        // Emissions are counted at decision time; each becomes exactly one de_o pulse.
        if (hs_i && !hs_prev_q) begin
            pix_cnt_d = cnt_q;
            cnt_d     = '0;
        end else if (s1_vld_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Interpolation stage and output register; do_o holds between valid pixels.
    always_comb begin
        s2_vld_d = s1_vld_q;
        s2_pix_d = s2_pix_q;
        if (s1_vld_q) begin
            s2_pix_d = pixel_out(s1_mode_q, s1_p0_q, s1_p1_q, s1_f_q);
        end else begin
            s2_pix_d = s2_pix_q;
        end
        de_d = s2_vld_q;
        do_d = s2_vld_q ? s2_pix_q : do_q;
    end

    // State register for all stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_dly_q  <= '0;
            vs_dly_q  <= '0;
            hs_prev_q <= 1'b0;
            line_ok_q <= 1'b0;
            armed_q   <= 1'b0;
            step_q    <= '0;
            mode_q    <= '0;
            n_q       <= '0;
            pos_q     <= '0;
            prev_q    <= '0;
            cnt_q     <= '0;
            pix_cnt_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_mode_q <= '0;
            s1_p0_q   <= '0;
            s1_p1_q   <= '0;
            s1_f_q    <= '0;
            s2_vld_q  <= 1'b0;
            s2_pix_q  <= '0;
            de_q      <= 1'b0;
            do_q      <= '0;
        end else begin
            hs_dly_q  <= hs_dly_d;
            vs_dly_q  <= vs_dly_d;
            hs_prev_q <= hs_prev_d;
            line_ok_q <= line_ok_d;
            armed_q   <= armed_d;
            step_q    <= step_d;
            mode_q    <= mode_d;
            n_q       <= n_d;
            pos_q     <= pos_d;
            prev_q    <= prev_d;
            cnt_q     <= cnt_d;
            pix_cnt_q <= pix_cnt_d;
            s1_vld_q  <= s1_vld_d;
            s1_mode_q <= s1_mode_d;
            s1_p0_q   <= s1_p0_d;
            s1_p1_q   <= s1_p1_d;
            s1_f_q    <= s1_f_d;
            s2_vld_q  <= s2_vld_d;
            s2_pix_q  <= s2_pix_d;
            de_q      <= de_d;
            do_q      <= do_d;
        end
    end

    assign do_o      = do_q;
    assign de_o      = de_q;
    assign hs_o      = hs_dly_q[2];
    assign vs_o      = vs_dly_q[2];
    assign pix_cnt_o = pix_cnt_q;

endmodule

// File: tb/tb_scaler_h_mc.sv
// Self-checking bench for scaler_h_mc: table-driven lines, a mid-line reset sequence and
// random lines, all compared against a sample-position reference model.
module tb_scaler_h_mc;
    localparam int DW = 8;
    localparam int CH = 3;
    localparam int FW = 12;
    localparam int IW = 4;
    localparam int LSM = 4096;
    localparam int PW = DW * CH;
    localparam int CW = $clog2(LSM) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [IW+FW-1:0] scale_step = '0;
    logic [1:0]    mode = '0;
    logic [PW-1:0] di_i = '0;
    logic          de_i = 1'b0, hs_i = 1'b1, vs_i = 1'b0;
    logic [PW-1:0] do_o;
    logic          de_o, hs_o, vs_o;
    logic [CW-1:0] pix_cnt_o;

    scaler_h_mc #(.DATA_WIDTH(DW), .CH_COUNT(CH), .FRAC_W(FW), .INT_W(IW), .LINE_SIZE_MAX(LSM)) dut (
        .clk(clk), .rst_n(rst_n), .scale_step(scale_step), .mode(mode), .di_i(di_i), .de_i(de_i),
        .hs_i(hs_i), .vs_i(vs_i), .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o), .pix_cnt_o(pix_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [PW-1:0] data; int cyc; } exp_t;
    typedef struct { int md; int step; int width; int gap; int pat; int kind; int exp_cnt; } vec_t;

    exp_t q[$];
    int checks = 0, failures = 0;
    int cyc = 0;
    logic [2:0] hist, vhist;
    logic [PW-1:0] last_do = '0;
    bit scr = 0;
    int m_mode, m_step, m_n, m_k, m_emit;
    logic [PW-1:0] m_prev;
    bit m_first, m_dead;
    int cur_pat = 0, cur_kind = 0, out_idx = 0, prev_exp = 0;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference sample: channel-wise nearest or rounded linear blend at phase f (0..4095).
    function automatic logic [PW-1:0] ref_px(input int md, input logic [PW-1:0] a, input logic [PW-1:0] b, input int f);
        logic [PW-1:0] r;
        int x, y, v;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            x = int'(a[c*DW +: DW]);
            y = int'(b[c*DW +: DW]);
            if (md == 1) v = (f < 2048) ? x : y;
            else         v = (x * (4096 - f) + y * f + 2048) / 4096;
            r[c*DW +: DW] = DW'(v);
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] gen_px(input int pat, input int x);
        logic [DW-1:0] v;
        v = DW'(x);
        case (pat)
            0:       return {v, v, v};
            1:       return {8'hFF - v, 8'hFF, v};
            default: return PW'($urandom);
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= '0;
            vhist <= '0;
        end else begin
            hist  <= {hist[1:0], hs_i};
            vhist <= {vhist[1:0], vs_i};
        end
    end

    // Output monitor: delays, scoreboard order/timing/data, hold behaviour and pattern properties.
    always @(negedge clk) begin
        exp_t e;
        int fv;
        if (rst_n) begin
            chk("hs_delay", 64'(hs_o), 64'(hist[2]));
            chk("vs_delay", 64'(vs_o), 64'(vhist[2]));
            if (de_o) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_de_o actual=1 required=0 (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("do_o", 64'(do_o), 64'(e.data));
                    chk("latency_cycle", 64'(cyc), 64'(e.cyc));
                end
                if (cur_pat == 1) begin
                    chk("ch1_const", 64'(do_o[DW +: DW]), 64'hFF);
                    fv = int'(do_o[0 +: DW]) + int'(do_o[2*DW +: DW]);
                    chk("ch0_plus_ch2", 64'((fv == 255) || (fv == 256)), 64'd1);
                end
                fv = -1;
                case (cur_kind)
                    1: fv = out_idx % 256;
                    2: if (out_idx < 160) fv = (3 * out_idx + 1) / 2;
                    3: if (out_idx < 120) fv = 2 * out_idx;
                    4: if (out_idx < 250) fv = out_idx;
                    default: fv = -1;
                endcase
                if (fv >= 0) chk("ramp_formula", 64'(do_o[0 +: DW]), 64'(fv));
                out_idx++;
                last_do = do_o;
            end else begin
                chk("do_hold", 64'(do_o), 64'(last_do));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (scr) begin
            scale_step = 16'($urandom);
            mode       = 2'($urandom);
        end
    endtask

    task automatic send_pix(input logic [PW-1:0] d);
        int pos, f;
        tick();
        de_i = 1'b1;
        di_i = d;
        if (!m_dead) begin
            if (m_first) begin
                m_mode  = int'(mode);
                m_step  = (int'(scale_step) < 4096) ? 4096 : int'(scale_step);
                m_first = 0;
            end
            if (m_mode == 0) begin
                q.push_back('{d, cyc + 3});
                m_emit++;
            end else begin
                pos = m_k * m_step;
                f   = pos % 4096;
                if (m_n >= 1 && pos / 4096 == m_n - 1) begin
                    q.push_back('{ref_px(m_mode, m_prev, d, f), cyc + 3});
                    m_k++;
                    m_emit++;
                end
            end
            m_prev = d;
            m_n++;
        end
        scr = 1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            de_i = 1'b0;
            di_i = PW'($urandom);
        end
    endtask

    task automatic hs_gap(input int exp_cnt);
        for (int i = 0; i < 4; i++) begin
            tick();
            de_i = 1'b0;
            hs_i = 1'b1;
            vs_i = 1'($urandom);
        end
        chk("pix_cnt", 64'(pix_cnt_o), 64'(exp_cnt));
        chk("line_drained", 64'(q.size()), 64'd0);
        scr = 0;
        m_n = 0; m_k = 0; m_emit = 0; m_prev = '0; m_first = 1; m_dead = 0;
        out_idx = 0;
    endtask

    task automatic run_line(input int md, input int step, input int width, input int gap, input int pat, input int kind);
        int g;
        hs_gap(prev_exp);
        mode = 2'(md);
        scale_step = 16'(step);
        cur_pat = pat;
        cur_kind = kind;
        tick();
        hs_i = 1'b0;
        vs_i = 1'b0;
        for (int x = 0; x < width; x++) begin
            send_pix(gen_px(pat, x));
            g = (gap == 3) ? int'($urandom_range(0, 2)) : gap;
            idle(g);
        end
        idle(5);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 4096, 600, 1, 0, 1, 600};
        tbl[1] = '{2, 6144, 600, 0, 0, 2, 400};
        tbl[2] = '{1, 8192, 600, 0, 0, 3, 300};
        tbl[3] = '{2, 2048, 600, 0, 0, 4, 599};
        tbl[4] = '{2, 6144, 600, 0, 1, 0, 400};
        tbl[5] = '{3, 6144, 600, 3, 2, 0, 400};

        #2 rst_n = 1'b0;
        #1;
        chk("reset_de_o", 64'(de_o), 64'd0);
        chk("reset_do_o", 64'(do_o), 64'd0);
        chk("reset_hs_o", 64'(hs_o), 64'd0);
        chk("reset_vs_o", 64'(vs_o), 64'd0);
        chk("reset_pix_cnt", 64'(pix_cnt_o), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        prev_exp = 0;
        for (int i = 0; i < 6; i++) begin
            run_line(tbl[i].md, tbl[i].step, tbl[i].width, tbl[i].gap, tbl[i].pat, tbl[i].kind);
            prev_exp = tbl[i].exp_cnt;
        end

        // Reset pulse at pixel 300 of a linear 1.5 line, then a clean line.
        hs_gap(prev_exp);
        mode = 2'd2;
        scale_step = 16'd6144;
        cur_pat = 0;
        cur_kind = 0;
        tick();
        hs_i = 1'b0;
        for (int x = 0; x < 300; x++) send_pix(gen_px(0, x));
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_de_o", 64'(de_o), 64'd0);
        chk("midrst_do_o", 64'(do_o), 64'd0);
        chk("midrst_hs_o", 64'(hs_o), 64'd0);
        chk("midrst_vs_o", 64'(vs_o), 64'd0);
        chk("midrst_pix_cnt", 64'(pix_cnt_o), 64'd0);
        q.delete();
        m_dead = 1;
        last_do = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int x = 300; x < 600; x++) send_pix(gen_px(0, x));
        idle(5);
        prev_exp = 0;
        run_line(2, 6144, 600, 0, 0, 2);
        prev_exp = 400;

        for (int r = 0; r < 12; r++) begin
            run_line(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
                     int'($urandom_range(2, 150)), 3, 2, 0);
            prev_exp = m_emit;
        end
        hs_gap(prev_exp);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
